// File: rtl/uart_rx_frame.sv
// UART frame receiver: start, DATA_WIDTH data bits LSB first, parity, stop; valid/ready output.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around mid-bit.
module uart_rx_frame #(
    parameter int BR         = 434,
    parameter int DATA_WIDTH = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_vld,
    input  logic                  rx_rdy,
    output logic                  par_err,
    output logic                  frm_err,
    output logic                  overrun,
    output logic                  busy
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

    localparam int              BCW      = $clog2(DATA_WIDTH + 1);
    localparam logic [8:0]      BR_LAST  = 9'(BR - 1);
    localparam logic [BCW-1:0]  BIT_LAST = BCW'(DATA_WIDTH - 1);

    state_t                  state_reg, state_next;
    logic                    rx_meta_reg, rx_s_reg, rx_d_reg;
    logic [8:0]              br_cnt_reg;
    logic [BCW-1:0]          bit_cnt_reg;
    logic [DATA_WIDTH-1:0]   shift_reg;
    logic                    par_flag_reg;
    logic [DATA_WIDTH-1:0]   rx_data_reg;
    logic                    rx_vld_reg, par_err_reg, frm_err_reg, overrun_reg;
    logic                    fall, sample_pt, bit_val;
    logic                    br_clr, load, ovr;

`ifdef UART_RX_MAJORITY_EN
    localparam logic [8:0] SAMPLE_PT = 9'(BR / 2 + 1);
    logic [1:0] maj_reg;

    // Early samples at BR/2-1 and BR/2; the vote is taken with the live sample at BR/2+1.
    always_ff @(posedge clk) begin
        if (rst) begin
            maj_reg <= 2'b11;
        end else if (br_cnt_reg == 9'(BR / 2 - 1)) begin
            maj_reg[0] <= rx_s_reg;
        end else if (br_cnt_reg == 9'(BR / 2)) begin
            maj_reg[1] <= rx_s_reg;
        end
    end
    assign bit_val = (maj_reg[0] & maj_reg[1]) | (maj_reg[0] & rx_s_reg) | (maj_reg[1] & rx_s_reg);
`else
    localparam logic [8:0] SAMPLE_PT = 9'(BR / 2);
    assign bit_val = rx_s_reg;
`endif

    assign fall      = rx_d_reg & ~rx_s_reg;
    assign sample_pt = (br_cnt_reg == SAMPLE_PT);

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
            rx_d_reg    <= 1'b1;
            state_reg   <= IDLE;
        end else begin
            rx_meta_reg <= rx;
            rx_s_reg    <= rx_meta_reg;
            rx_d_reg    <= rx_s_reg;
            state_reg   <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        br_clr     = 1'b0;
        load       = 1'b0;
        ovr        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (fall) begin
                    state_next = START;
                    br_clr     = 1'b1;
                end
            end
            START:     if (sample_pt) state_next = bit_val ? IDLE : DATA;
            DATA:      if (sample_pt && bit_cnt_reg == BIT_LAST) state_next = PARITY;
            PARITY:    if (sample_pt) state_next = STOP;
            STOP: begin
                if (sample_pt) begin
                    // A same-cycle handshake frees the output register, so this is not an overrun.
                    load       = ~rx_vld_reg | rx_rdy;
                    ovr        = rx_vld_reg & ~rx_rdy;
                    state_next = bit_val ? IDLE : WAIT_IDLE;
                end
            end
            WAIT_IDLE: if (rx_s_reg) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // br_cnt is phased to the start edge and wraps every bit, so BR/2 stays mid-bit for every bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            br_cnt_reg   <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            par_flag_reg <= 1'b0;
        end else begin
            if (br_clr || state_reg == IDLE || br_cnt_reg == BR_LAST) begin
                br_cnt_reg <= '0;
            end else begin
                br_cnt_reg <= br_cnt_reg + 9'd1;
            end

            if (state_reg == IDLE) begin
                bit_cnt_reg <= '0;
            end else if (state_reg == DATA && sample_pt) begin
                bit_cnt_reg <= (bit_cnt_reg == BIT_LAST) ? '0 : bit_cnt_reg + 1'b1;
                shift_reg   <= {bit_val, shift_reg} >> 1;
            end

            if (state_reg == PARITY && sample_pt) begin
                par_flag_reg <= ((^shift_reg) ^ PARITY_ODD) != bit_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data_reg <= '0;
            rx_vld_reg  <= 1'b0;
            par_err_reg <= 1'b0;
            frm_err_reg <= 1'b0;
            overrun_reg <= 1'b0;
        end else begin
            overrun_reg <= ovr;
            if (load) begin
                rx_data_reg <= shift_reg;
                par_err_reg <= par_flag_reg;
                frm_err_reg <= ~bit_val;
                rx_vld_reg  <= 1'b1;
            end else if (rx_vld_reg && rx_rdy) begin
                rx_vld_reg  <= 1'b0;
            end
        end
    end

    assign rx_data = rx_data_reg;
    assign rx_vld  = rx_vld_reg;
    assign par_err = par_err_reg;
    assign frm_err = frm_err_reg;
    assign overrun = overrun_reg;
    assign busy    = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame at BR=16: directed frames, queue of expected bytes, handshake monitor.
module tb_uart_rx_frame;

    localparam int BR = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       rx_rdy = 1'b0;
    logic [7:0] rx_data;
    logic       rx_vld, par_err, frm_err, overrun, busy;

    typedef struct packed {
        logic [7:0] d;
        logic       p;
        logic       f;
    } exp_t;

    exp_t exp_q[$];
    int   checks    = 0;
    int   failures  = 0;
    int   ovr_count = 0;

    uart_rx_frame #(.BR(BR), .DATA_WIDTH(8), .PARITY_ODD(1'b0)) dut (
        .clk     (clk),
        .rst     (rst),
        .rx      (rx),
        .rx_data (rx_data),
        .rx_vld  (rx_vld),
        .rx_rdy  (rx_rdy),
        .par_err (par_err),
        .frm_err (frm_err),
        .overrun (overrun),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end else begin
            $display("ok   %s value=%0h", name, act);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Drives one frame; gbit >= 0 flips the line for one cycle in the middle of that data bit.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int gbit);
        rx = 1'b0;
        cyc(BR);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            if (i == gbit) begin
                cyc(BR / 2);
                rx = ~d[i];
                cyc(1);
                rx = d[i];
                cyc(BR - BR / 2 - 1);
            end else begin
                cyc(BR);
            end
        end
        rx = p;
        cyc(BR);
        rx = s;
        cyc(BR);
    endtask

    // Monitor: every accepted transfer pops one expected entry.
    always @(negedge clk) begin
        if (!rst && rx_vld && rx_rdy) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_transfer", {24'd0, rx_data}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("xfer_data", {24'd0, rx_data}, {24'd0, e.d});
                chk("xfer_par_err", {31'd0, par_err}, {31'd0, e.p});
                chk("xfer_frm_err", {31'd0, frm_err}, {31'd0, e.f});
            end
        end
        if (!rst && overrun) ovr_count++;
    end

    initial begin
        cyc(3);
        chk("rst_vld", {31'd0, rx_vld}, 0);
        chk("rst_data", {24'd0, rx_data}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_overrun", {31'd0, overrun}, 0);
        rst = 1'b0;
        rx_rdy = 1'b1;
        cyc(2 * BR);

        // Clean frame 0xA5, even parity bit 0.
        exp_q.push_back('{d: 8'hA5, p: 1'b0, f: 1'b0});
        send_frame(8'hA5, 1'b0, 1'b1, -1);
        cyc(2);
        chk("a5_busy_after_stop", {31'd0, busy}, 0);
        cyc(2 * BR);

        // 0x3C has four ones, so parity bit 1 is wrong for even parity.
        exp_q.push_back('{d: 8'h3C, p: 1'b1, f: 1'b0});
        send_frame(8'h3C, 1'b1, 1'b1, -1);
        cyc(2 * BR);

        // 0x81 with a low stop bit, then the line stays low.
        exp_q.push_back('{d: 8'h81, p: 1'b0, f: 1'b1});
        send_frame(8'h81, 1'b0, 1'b0, -1);
        rx = 1'b0;
        cyc(300);
        chk("break_busy", {31'd0, busy}, 1);
        chk("break_vld", {31'd0, rx_vld}, 0);
        rx = 1'b1;
        cyc(2 * BR);
        chk("break_released_busy", {31'd0, busy}, 0);
        exp_q.push_back('{d: 8'h55, p: 1'b0, f: 1'b0});
        send_frame(8'h55, 1'b0, 1'b1, -1);
        cyc(2 * BR);

        // Short low glitch on an idle line.
        rx = 1'b0;
        cyc(6);
        rx = 1'b1;
        cyc(2);
        chk("glitch_busy_start", {31'd0, busy}, 1);
        cyc(2 * BR);
        chk("glitch_busy_end", {31'd0, busy}, 0);
        chk("glitch_vld", {31'd0, rx_vld}, 0);

        // Back-to-back 0x11, 0x22 with the consumer stalled: 0x22 is dropped.
        rx_rdy = 1'b0;
        ovr_count = 0;
        exp_q.push_back('{d: 8'h11, p: 1'b0, f: 1'b0});
        send_frame(8'h11, 1'b0, 1'b1, -1);
        send_frame(8'h22, 1'b0, 1'b1, -1);
        cyc(4);
        chk("ovr_held_vld", {31'd0, rx_vld}, 1);
        chk("ovr_held_data", {24'd0, rx_data}, 32'h11);
        chk("ovr_pulses", ovr_count, 1);
        rx_rdy = 1'b1;
        cyc(2);
        chk("ovr_vld_dropped", {31'd0, rx_vld}, 0);
        cyc(2 * BR);

        // Held byte 0x33 and partial frame 0xF0 are both discarded by reset.
        rx_rdy = 1'b0;
        send_frame(8'h33, 1'b0, 1'b1, -1);
        cyc(4);
        chk("held_before_rst", {31'd0, rx_vld}, 1);
        rx = 1'b0;
        cyc(BR);
        rx = 1'b0;
        cyc(3 * BR + BR / 2);
        rst = 1'b1;
        cyc(1);
        chk("midrst_vld", {31'd0, rx_vld}, 0);
        chk("midrst_data", {24'd0, rx_data}, 0);
        chk("midrst_busy", {31'd0, busy}, 0);
        chk("midrst_errs", {30'd0, par_err, frm_err}, 0);
        rst = 1'b0;
        rx = 1'b1;
        rx_rdy = 1'b1;
        cyc(3 * BR);
        exp_q.push_back('{d: 8'h0F, p: 1'b0, f: 1'b0});
        send_frame(8'h0F, 1'b0, 1'b1, -1);
        cyc(2 * BR);

`ifdef UART_RX_MAJORITY_EN
        // One-cycle glitch in the middle of data bit 2 is out-voted.
        exp_q.push_back('{d: 8'h5A, p: 1'b0, f: 1'b0});
        send_frame(8'h5A, 1'b0, 1'b1, 2);
        cyc(2 * BR);
`endif

        cyc(20);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
